// File: rtl/control_unit_seq_if.sv
// rtl/control_unit_seq_if.sv - EX/WB control bundle between the pipeline and control_unit_seq
interface control_unit_seq_if #(
  parameter int GPIO_CH = 4
);
  localparam int CHW = (GPIO_CH > 1) ? $clog2(GPIO_CH) : 1;

  logic [31:0]    instruction_EX;
  logic           zero_EX;
  logic [3:0]     alu_op;
  logic [4:0]     shamt_EX;
  logic [1:0]     alu_src_EX;
  logic           rdrt_EX;
  logic           enhilo_EX;
  logic [1:0]     pc_src_EX;
  logic           stall_FETCH;
  logic [CHW-1:0] gpio_sel_EX;
  logic           regwrite_WB;
  logic [1:0]     regsel_WB;
  logic           gpio_out_WB;
  logic           mult_busy;
  logic           illegal;

  modport master (
    output instruction_EX, zero_EX,
    input  alu_op, shamt_EX, alu_src_EX, rdrt_EX, enhilo_EX, pc_src_EX, stall_FETCH,
           gpio_sel_EX, regwrite_WB, regsel_WB, gpio_out_WB, mult_busy, illegal
  );

  modport slave (
    input  instruction_EX, zero_EX,
    output alu_op, shamt_EX, alu_src_EX, rdrt_EX, enhilo_EX, pc_src_EX, stall_FETCH,
           gpio_sel_EX, regwrite_WB, regsel_WB, gpio_out_WB, mult_busy, illegal
  );
endinterface

// File: rtl/control_unit_seq.sv
// rtl/control_unit_seq.sv - EX-stage MIPS control decoder with branch squash, HI/LO interlock and GPIO
module control_unit_seq #(
  parameter int MULT_CYCLES = 4,
  parameter int GPIO_CH     = 4
) (
  input  logic               clk,
  input  logic               rst,
  control_unit_seq_if.slave  bus
);
  localparam int CHW = (GPIO_CH > 1) ? $clog2(GPIO_CH) : 1;
  localparam int MCW = $clog2(MULT_CYCLES + 1);

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] SQUASH = 1'b1;

  localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR  = 4'b0001, ALU_NOR  = 4'b0010,
                         ALU_XOR = 4'b0011, ALU_ADD = 4'b0100, ALU_SUB  = 4'b0101,
                         ALU_MUL = 4'b0110, ALU_MULU = 4'b0111, ALU_SLL = 4'b1000,
                         ALU_SRL = 4'b1001, ALU_SRA = 4'b1010, ALU_SLT  = 4'b1100,
                         ALU_SLTU = 4'b1101;

  logic [31:0] instr;
  logic [5:0]  op_f, funct_f;
  logic [4:0]  rs_f, rd_f, sh_f;

  assign instr   = bus.instruction_EX;
  assign op_f    = instr[31:26];
  assign rs_f    = instr[25:21];
  assign rd_f    = instr[15:11];
  assign sh_f    = instr[10:6];
  assign funct_f = instr[5:0];

  logic [3:0]     d_alu_op;
  logic [4:0]     d_shamt;
  logic [1:0]     d_alu_src, d_pc_src, d_regsel;
  logic           d_rdrt, d_enhilo, d_regwrite, d_gpio_out, d_illegal, d_hilo;
  logic [CHW-1:0] d_gpio_sel;

  always_comb begin
    d_alu_op   = '0;
    d_shamt    = '0;
    d_alu_src  = '0;
    d_pc_src   = '0;
    d_regsel   = '0;
    d_rdrt     = 1'b0;
    d_enhilo   = 1'b0;
    d_regwrite = 1'b0;
    d_gpio_out = 1'b0;
    d_illegal  = 1'b0;
    d_hilo     = 1'b0;
    d_gpio_sel = '0;
    if (instr != 32'h0000_0000) begin
      case (op_f)
        6'b000000: begin
          case (funct_f)
            6'b100000, 6'b100001: begin d_alu_op = ALU_ADD;  d_regwrite = 1'b1; end
            6'b100010, 6'b100011: begin d_alu_op = ALU_SUB;  d_regwrite = 1'b1; end
            6'b100100:            begin d_alu_op = ALU_AND;  d_regwrite = 1'b1; end
            6'b100101:            begin d_alu_op = ALU_OR;   d_regwrite = 1'b1; end
            6'b100110:            begin d_alu_op = ALU_XOR;  d_regwrite = 1'b1; end
            6'b100111:            begin d_alu_op = ALU_NOR;  d_regwrite = 1'b1; end
            6'b101010:            begin d_alu_op = ALU_SLT;  d_regwrite = 1'b1; end
            6'b101011:            begin d_alu_op = ALU_SLTU; d_regwrite = 1'b1; end
            6'b000000: begin
              if (sh_f != 5'd0) begin
                d_alu_op = ALU_SLL; d_shamt = sh_f; d_regwrite = 1'b1;
              end else begin
                d_illegal = 1'b1;
              end
            end
            // srl/sra with a zero shift are repurposed as GPIO write/read
            6'b000010: begin
              if (sh_f != 5'd0) begin
                d_alu_op = ALU_SRL; d_shamt = sh_f; d_regwrite = 1'b1;
              end else if ({27'd0, rd_f} >= 32'(GPIO_CH)) begin
                d_illegal = 1'b1;
              end else begin
                d_gpio_out = 1'b1; d_gpio_sel = rd_f[CHW-1:0];
              end
            end
            6'b000011: begin
              if (sh_f != 5'd0) begin
                d_alu_op = ALU_SRA; d_shamt = sh_f; d_regwrite = 1'b1;
              end else if ({27'd0, rs_f} >= 32'(GPIO_CH)) begin
                d_illegal = 1'b1;
              end else begin
                d_regsel = 2'd3; d_regwrite = 1'b1; d_gpio_sel = rs_f[CHW-1:0];
              end
            end
            6'b011000: begin d_alu_op = ALU_MUL;  d_enhilo = 1'b1; d_hilo = 1'b1; end
            6'b011001: begin d_alu_op = ALU_MULU; d_enhilo = 1'b1; d_hilo = 1'b1; end
            6'b010000: begin d_regsel = 2'd1; d_regwrite = 1'b1; d_hilo = 1'b1; end
            6'b010010: begin d_regsel = 2'd2; d_regwrite = 1'b1; d_hilo = 1'b1; end
            default:   d_illegal = 1'b1;
          endcase
        end
        6'b001000, 6'b001001: begin d_alu_op = ALU_ADD; d_alu_src = 2'd1; d_rdrt = 1'b1; d_regwrite = 1'b1; end
        6'b001100: begin d_alu_op = ALU_AND; d_alu_src = 2'd2; d_rdrt = 1'b1; d_regwrite = 1'b1; end
        6'b001101: begin d_alu_op = ALU_OR;  d_alu_src = 2'd2; d_rdrt = 1'b1; d_regwrite = 1'b1; end
        6'b001110: begin d_alu_op = ALU_XOR; d_alu_src = 2'd2; d_rdrt = 1'b1; d_regwrite = 1'b1; end
        6'b001010: begin d_alu_op = ALU_SLT; d_alu_src = 2'd1; d_rdrt = 1'b1; d_regwrite = 1'b1; end
        6'b001111: begin
          d_alu_op = ALU_SLL; d_shamt = 5'd16; d_alu_src = 2'd2; d_rdrt = 1'b1; d_regwrite = 1'b1;
        end
        6'b000100: begin d_alu_op = ALU_SUB; d_pc_src = bus.zero_EX ? 2'd1 : 2'd0; end
        6'b000101: begin d_alu_op = ALU_SUB; d_pc_src = bus.zero_EX ? 2'd0 : 2'd1; end
        6'b000010: d_pc_src = 2'd2;
        default:   d_illegal = 1'b1;
      endcase
    end
  end

  logic [0:0]     state_q, state_d;
  logic [MCW-1:0] mcnt_q, mcnt_d;
  logic           illegal_q, illegal_d;
  logic           regwrite_q, regwrite_d, gpio_out_q, gpio_out_d;
  logic [1:0]     regsel_q, regsel_d;
  logic           squash, busy, stall, kill;

  assign squash = (state_q == SQUASH);
  assign busy   = (mcnt_q != '0);
  // Squash outranks the interlock: a wrong-path instruction is dropped, never held
  assign stall  = !rst && !squash && busy && d_hilo;
  assign kill   = rst || squash || stall || d_illegal;

  assign bus.alu_op      = kill ? '0 : d_alu_op;
  assign bus.shamt_EX    = kill ? '0 : d_shamt;
  assign bus.alu_src_EX  = kill ? '0 : d_alu_src;
  assign bus.rdrt_EX     = kill ? 1'b0 : d_rdrt;
  assign bus.enhilo_EX   = kill ? 1'b0 : d_enhilo;
  assign bus.pc_src_EX   = kill ? '0 : d_pc_src;
  assign bus.gpio_sel_EX = kill ? '0 : d_gpio_sel;
  assign bus.stall_FETCH = stall;
  assign bus.mult_busy   = busy;
  assign bus.illegal     = illegal_q;
  assign bus.regwrite_WB = regwrite_q;
  assign bus.regsel_WB   = regsel_q;
  assign bus.gpio_out_WB = gpio_out_q;

  assign regwrite_d = kill ? 1'b0 : d_regwrite;
  assign regsel_d   = kill ? 2'd0 : d_regsel;
  assign gpio_out_d = kill ? 1'b0 : d_gpio_out;
  assign illegal_d  = illegal_q | (d_illegal & ~squash);
  assign state_d    = (!squash && bus.pc_src_EX != 2'd0) ? SQUASH : RUN;

  always_comb begin
    mcnt_d = mcnt_q;
    if (bus.enhilo_EX)
      mcnt_d = MCW'(MULT_CYCLES - 1);
    else if (busy)
      mcnt_d = mcnt_q - MCW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      mcnt_q     <= '0;
      illegal_q  <= 1'b0;
      regwrite_q <= 1'b0;
      regsel_q   <= 2'd0;
      gpio_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mcnt_q     <= mcnt_d;
      illegal_q  <= illegal_d;
      regwrite_q <= regwrite_d;
      regsel_q   <= regsel_d;
      gpio_out_q <= gpio_out_d;
    end
  end
endmodule

// File: tb/tb_control_unit_seq.sv
// tb/tb_control_unit_seq.sv - directed self-checking bench for control_unit_seq
module tb_control_unit_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  control_unit_seq_if #(.GPIO_CH(4)) bus ();
  control_unit_seq #(.MULT_CYCLES(4), .GPIO_CH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic z);
    bus.instruction_EX = ins;
    bus.zero_EX        = z;
    #1;
  endtask

  localparam logic [31:0] ADD   = 32'h0022_1820;
  localparam logic [31:0] BEQ   = 32'h1022_0003;
  localparam logic [31:0] BNE   = 32'h1422_0003;
  localparam logic [31:0] ADDI  = 32'h2022_0005;
  localparam logic [31:0] MULT  = 32'h0022_0018;
  localparam logic [31:0] MFHI  = 32'h0000_1810;
  localparam logic [31:0] LUI   = 32'h3C01_0005;
  localparam logic [31:0] GPWR  = 32'h0001_1002;
  localparam logic [31:0] GPRD  = 32'h0020_1803;
  localparam logic [31:0] GPBAD = 32'h00A0_1803;
  localparam logic [31:0] JMP   = 32'h0800_0010;
  localparam logic [31:0] OP3F  = 32'hFC00_0000;

  initial begin
    bus.instruction_EX = ADD;
    bus.zero_EX        = 1'b0;
    #2;
    chk("rst_alu_op", 32'(bus.alu_op), 32'd0);
    chk("rst_rdrt", 32'(bus.rdrt_EX), 32'd0);
    chk("rst_stall", 32'(bus.stall_FETCH), 32'd0);
    chk("rst_regwrite_wb", 32'(bus.regwrite_WB), 32'd0);
    chk("rst_mult_busy", 32'(bus.mult_busy), 32'd0);
    chk("rst_illegal", 32'(bus.illegal), 32'd0);
    step();
    step();
    rst = 1'b0;

    drive(ADD, 1'b0);
    chk("add_alu_op", 32'(bus.alu_op), 32'd4);
    chk("add_rdrt", 32'(bus.rdrt_EX), 32'd0);
    step();
    chk("add_regwrite_wb", 32'(bus.regwrite_WB), 32'd1);
    chk("add_regsel_wb", 32'(bus.regsel_WB), 32'd0);

    drive(BEQ, 1'b1);
    chk("beq_pc_src", 32'(bus.pc_src_EX), 32'd1);
    chk("beq_alu_op", 32'(bus.alu_op), 32'd5);
    step();
    drive(ADDI, 1'b0);
    chk("squash_alu_op", 32'(bus.alu_op), 32'd0);
    chk("squash_rdrt", 32'(bus.rdrt_EX), 32'd0);
    step();
    chk("squash_regwrite_wb", 32'(bus.regwrite_WB), 32'd0);
    drive(ADDI, 1'b0);
    chk("addi_alu_op", 32'(bus.alu_op), 32'd4);
    chk("addi_alu_src", 32'(bus.alu_src_EX), 32'd1);
    chk("addi_rdrt", 32'(bus.rdrt_EX), 32'd1);
    step();

    drive(BNE, 1'b1);
    chk("bne_nt_pc_src", 32'(bus.pc_src_EX), 32'd0);
    step();
    drive(ADDI, 1'b0);
    chk("bne_no_squash", 32'(bus.alu_op), 32'd4);
    step();
    chk("bne_next_regwrite_wb", 32'(bus.regwrite_WB), 32'd1);

    drive(MULT, 1'b0);
    chk("mult_enhilo", 32'(bus.enhilo_EX), 32'd1);
    chk("mult_stall", 32'(bus.stall_FETCH), 32'd0);
    step();
    drive(MFHI, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("mfhi_stall", 32'(bus.stall_FETCH), 32'd1);
      chk("mfhi_busy", 32'(bus.mult_busy), 32'd1);
      step();
      chk("mfhi_stall_regwrite_wb", 32'(bus.regwrite_WB), 32'd0);
    end
    chk("mfhi_release_stall", 32'(bus.stall_FETCH), 32'd0);
    chk("mfhi_release_busy", 32'(bus.mult_busy), 32'd0);
    step();
    chk("mfhi_regwrite_wb", 32'(bus.regwrite_WB), 32'd1);
    chk("mfhi_regsel_wb", 32'(bus.regsel_WB), 32'd1);

    drive(LUI, 1'b0);
    chk("lui_alu_op", 32'(bus.alu_op), 32'd8);
    chk("lui_shamt", 32'(bus.shamt_EX), 32'd16);
    chk("lui_alu_src", 32'(bus.alu_src_EX), 32'd2);
    chk("lui_rdrt", 32'(bus.rdrt_EX), 32'd1);
    step();

    drive(GPWR, 1'b0);
    chk("gpwr_sel", 32'(bus.gpio_sel_EX), 32'd2);
    step();
    chk("gpwr_gpio_out_wb", 32'(bus.gpio_out_WB), 32'd1);
    chk("gpwr_regwrite_wb", 32'(bus.regwrite_WB), 32'd0);

    drive(GPRD, 1'b0);
    chk("gprd_sel", 32'(bus.gpio_sel_EX), 32'd1);
    step();
    chk("gprd_regsel_wb", 32'(bus.regsel_WB), 32'd3);
    chk("gprd_gpio_out_wb", 32'(bus.gpio_out_WB), 32'd0);

    drive(JMP, 1'b0);
    chk("j_pc_src", 32'(bus.pc_src_EX), 32'd2);
    step();
    drive(OP3F, 1'b0);
    chk("op3f_squash_alu_op", 32'(bus.alu_op), 32'd0);
    step();
    chk("op3f_squash_not_illegal", 32'(bus.illegal), 32'd0);

    drive(GPBAD, 1'b0);
    chk("gpbad_sel", 32'(bus.gpio_sel_EX), 32'd0);
    chk("gpbad_pre_edge_illegal", 32'(bus.illegal), 32'd0);
    step();
    chk("gpbad_illegal", 32'(bus.illegal), 32'd1);
    chk("gpbad_regwrite_wb", 32'(bus.regwrite_WB), 32'd0);
    drive(ADD, 1'b0);
    step();
    chk("illegal_sticky", 32'(bus.illegal), 32'd1);

    drive(MULT, 1'b0);
    step();
    drive(MFHI, 1'b0);
    step();
    chk("pre_rst_stall", 32'(bus.stall_FETCH), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_busy", 32'(bus.mult_busy), 32'd0);
    chk("async_rst_stall", 32'(bus.stall_FETCH), 32'd0);
    chk("async_rst_regwrite_wb", 32'(bus.regwrite_WB), 32'd0);
    chk("async_rst_regsel_wb", 32'(bus.regsel_WB), 32'd0);
    chk("async_rst_illegal", 32'(bus.illegal), 32'd0);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_mfhi_stall", 32'(bus.stall_FETCH), 32'd0);
    step();
    chk("post_rst_mfhi_regsel_wb", 32'(bus.regsel_WB), 32'd1);
    chk("post_rst_mfhi_regwrite_wb", 32'(bus.regwrite_WB), 32'd1);

    drive(OP3F, 1'b0);
    chk("op3f_run_alu_op", 32'(bus.alu_op), 32'd0);
    step();
    chk("op3f_run_illegal", 32'(bus.illegal), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/control_unit_seq.md
# control_unit_seq

Parametrised, stateful successor to the single-cycle MIPS control decoder. It sits in the EX stage of the 3-stage fetch/EX/WB pipeline. Each cycle it decodes `instruction_EX` into EX control and registers the writeback controls into WB. Beyond plain decode it adds:
- branch/jump resolution with a one-cycle wrong-path squash;
- a HI/LO interlock for a multi-cycle multiplier;
- a multi-channel GPIO mode;
- sticky illegal-instruction detection.

## Interface
- `MULT_CYCLES`, default 4: multiplier latency in cycles, ≥1. A value of 1 disables the interlock.
- `GPIO_CH`, default 4: number of GPIO channels, 1..32. `CHW = max(1, $clog2(GPIO_CH))`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `instruction_EX` in 32: instruction currently in EX.
- `zero_EX` in 1: ALU zero flag for the current EX instruction.
- `alu_op` out 4: AND 0000, OR 0001, NOR 0010, XOR 0011, ADD 0100, SUB 0101, MULT 0110, MULTU 0111, SLL 1000, SRL 1001, SRA 1010, SLT 1100, SLTU 1101.
- `shamt_EX` out 5: shift amount.
- `alu_src_EX` out 2: B operand select. 0 = rt, 1 = sign-extended imm, 2 = zero-extended imm.
- `rdrt_EX` out 1: destination select. 1 = rt, 0 = rd.
- `enhilo_EX` out 1: HI/LO write enable (mult/multu).
- `pc_src_EX` out 2: 0 = PC+4, 1 = branch target, 2 = jump target.
- `stall_FETCH` out 1: hold the PC and the EX instruction register this cycle.
- `gpio_sel_EX` out CHW: selected GPIO channel.
- `regwrite_WB` out 1: registered regwrite.
- `regsel_WB` out 2: registered regsel. 0 = ALU, 1 = HI, 2 = LO, 3 = GPIO in.
- `gpio_out_WB` out 1: registered GPIO write strobe.
- `mult_busy` out 1: multiplier result pending.
- `illegal` out 1: sticky; set on any illegal decode.

## Operation
All EX outputs are combinational from `instruction_EX`, `zero_EX` and state. Any field not listed for an instruction drives 0; X is never driven.

A **bubble** is every output 0, including all enables.

Decode:
- **Word 0x00000000:** bubble.
- **R-type ALU ops** (`op` = 0): add/addu, sub/subu, and, or, nor, xor, slt, sltu. ALU op as encoded above, `regwrite` = 1, `rdrt` = 0.
- **sll, srl, sra** (shamt ≠ 0): ALU op as encoded, `shamt_EX` = shamt, `regwrite` = 1.
- **mult, multu:** `enhilo_EX` = 1, `regwrite` = 0; load the multiplier counter.
- **mfhi / mflo:** `regsel` 1 / 2, `regwrite` = 1.
- **srl, shamt = 0 (GPIO write):** `gpio_out` = 1, `gpio_sel_EX` = rd[CHW-1:0], `regwrite` = 0.
- **sra, shamt = 0 (GPIO read):** `regsel` = 3, `regwrite` = 1, `gpio_sel_EX` = rs[CHW-1:0].
- **I-type ops**, all with `rdrt` = 1 and `regwrite` = 1:
  - addi/addiu: ADD, `alu_src` = 1.
  - andi/ori/xori: AND/OR/XOR, `alu_src` = 2.
  - slti: SLT, `alu_src` = 1.
  - lui: SLL, `shamt_EX` = 16, `alu_src` = 2.
- **beq (000100) / bne (000101):** SUB, `alu_src` = 0, `regwrite` = 0. Taken when `zero_EX` = 1 for beq, or `zero_EX` = 0 for bne; taken gives `pc_src_EX` = 1.
- **j (000010):** always taken, `pc_src_EX` = 2.
- **Illegal:** any other encoding, or a GPIO channel index ≥ `GPIO_CH`. Decodes as a bubble and sets `illegal` on the next edge.

Branch FSM:
- States RUN and SQUASH; reset goes to RUN.
- In RUN, a taken branch or jump moves to SQUASH on the next edge.
- In SQUASH, the instruction in EX is the wrong path: the bubble is forced, `pc_src_EX` = 0, and illegal detection is suppressed. The FSM returns to RUN on the next edge.

Multiplier interlock:
- `mcnt` is a $clog2(MULT_CYCLES+1)-bit counter; `mult_busy` = (`mcnt` ≠ 0).
- An issued mult/multu loads `mcnt` = MULT_CYCLES−1. Otherwise `mcnt` decrements while nonzero.
- In RUN, with `mult_busy` = 1, any mfhi, mflo, mult or multu in EX asserts `stall_FETCH` = 1 and is converted to a bubble. It re-decodes each cycle until `mult_busy` = 0.
- SQUASH has priority over the interlock: a squashed instruction never stalls.
- A branch or jump is never held by the interlock.

WB registers: `regwrite_WB`, `regsel_WB` and `gpio_out_WB` capture the final (post-squash, post-stall) EX values every edge.

## Timing
- Decode latency is 0 cycles for EX outputs and 1 cycle for WB outputs.
- The branch penalty is exactly 1 squashed cycle.
- A mult followed immediately by mfhi stalls for MULT_CYCLES−1 cycles.
- Reset, including mid-multiply or mid-squash:
  - `mcnt` = 0, state = RUN, `illegal` = 0, all WB outputs 0.
  - While `rst` is high, all EX outputs are forced to bubble values and `stall_FETCH` = 0.
- Simultaneous mult issue while `mcnt` = 0: the load wins over the decrement.

## Test plan
- add $3,$1,$2 (0x00221820) → `alu_op` 0100, `rdrt` 0; next cycle `regwrite_WB` = 1, `regsel_WB` = 0.
- beq with `zero_EX` = 1, then any addi → `pc_src_EX` = 1 in cycle 0; the addi in cycle 1 is a bubble, giving `regwrite_WB` = 0 in cycle 2. bne with `zero_EX` = 1 → `pc_src_EX` = 0, no squash.
- MULT_CYCLES = 4: mult then mfhi held in EX → `stall_FETCH` = 1 for 3 cycles with `regwrite_WB` = 0, then `regsel_WB` = 1 and `regwrite_WB` = 1.
- GPIO_CH = 4: srl, shamt 0, rd = 2 → `gpio_sel_EX` = 2, `gpio_out_WB` = 1. sra, shamt 0, rs = 5 → bubble and `illegal` = 1, held until reset.
- lui → `alu_op` 1000, `shamt_EX` = 16, `alu_src` = 2, `rdrt` = 1. Opcode 0x3F → `illegal` rises; not flagged if presented during SQUASH.
- Assert `rst` asynchronously mid-stall (`mcnt` = 2) → `mult_busy`, `stall_FETCH` and all WB outputs go to 0 immediately. After release, mfhi decodes without stalling.
